// File: rtl/if_id_stage_if.sv
// Fetch-side RAM arbiter bus between the IF stage and the instruction/data RAM arbiter.
// master = fetch stage, slave = arbiter.
interface if_id_stage_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
);
  logic              IMEM_REQ;
  logic [PC_W-1:0]   IMEM_ADDR;
  logic              IMEM_GNT;
  logic [INST_W-1:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RDATA
  );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch stage + IF/ID pipeline register with a one-entry skid.
// Optional perf counters: define IF_ID_PERF_CNT_EN.
module if_id_stage #(
  parameter int                PC_W     = 16,
  parameter int                INST_W   = 16,
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_ID_PAUSE,
  input  logic              JUMP_EN,
  input  logic [PC_W-1:0]   JUMP_ADDR,
  if_id_stage_if.master     imem,
  output logic [INST_W-1:0] IF_ID_INST,
  output logic [PC_W-1:0]   IF_ID_PC,
  output logic              IF_ID_VALID,
  output logic [15:0]       IF_FETCH_CNT,
  output logic [15:0]       IF_BUBBLE_CNT
);

  localparam logic PAUSE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    S_REQ,
    S_RESP,
    S_HOLD
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   fl_pc;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic              paused;
  logic              grant;
  logic              req;
  logic              ld_valid;
  logic              ld_bubble;
  logic              ld_skid;
  logic [INST_W-1:0] ld_inst;
  logic [PC_W-1:0]   ld_pc;

  assign paused = (IF_ID_PAUSE == PAUSE_ENABLE);
  assign grant  = req & imem.IMEM_GNT;

  assign imem.IMEM_REQ  = req;
  assign imem.IMEM_ADDR = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (JUMP_EN) begin
      state_n = S_REQ;
    end else begin
      unique case (state)
        S_REQ:   if (grant) state_n = S_RESP;
        S_RESP: begin
          if (paused)      state_n = S_HOLD;
          else if (!grant) state_n = S_REQ;
        end
        S_HOLD:  if (!paused) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_comb begin
    req       = 1'b0;
    ld_valid  = 1'b0;
    ld_bubble = 1'b0;
    ld_skid   = 1'b0;
    ld_inst   = NOP_INST;
    ld_pc     = '0;
    if (rst) begin
      req = 1'b0;
    end else if (JUMP_EN) begin
      ld_bubble = 1'b1;
    end else begin
      unique case (state)
        S_REQ: begin
          req       = 1'b1;
          ld_bubble = !paused;
        end
        S_RESP: begin
          if (paused) begin
            ld_skid = 1'b1;
          end else begin
            req      = 1'b1;
            ld_valid = 1'b1;
            ld_inst  = imem.IMEM_RDATA;
            ld_pc    = fl_pc + PC_W'(1);
          end
        end
        S_HOLD: begin
          if (!paused) begin
            ld_valid = 1'b1;
            ld_inst  = skid_inst;
            ld_pc    = skid_pc;
          end
        end
        default: req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fl_pc       <= RESET_PC;
      skid_inst   <= '0;
      skid_pc     <= '0;
      IF_ID_INST  <= NOP_INST;
      IF_ID_PC    <= '0;
      IF_ID_VALID <= 1'b0;
    end else begin
      if (JUMP_EN) begin
        pc <= JUMP_ADDR;
      end else if (grant) begin
        fl_pc <= pc;
        pc    <= pc + PC_W'(1);
      end
      if (ld_skid) begin
        skid_inst <= imem.IMEM_RDATA;
        skid_pc   <= fl_pc + PC_W'(1);
      end
      if (ld_valid || ld_bubble) begin
        IF_ID_INST  <= ld_inst;
        IF_ID_PC    <= ld_pc;
        IF_ID_VALID <= ld_valid;
      end
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ld_valid && fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
      if (ld_bubble && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign IF_FETCH_CNT  = fetch_cnt;
  assign IF_BUBBLE_CNT = bubble_cnt;
`else
  assign IF_FETCH_CNT  = 16'h0000;
  assign IF_BUBBLE_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: stream scoreboard model plus literal checkpoints.
// RAM returns addr^16'hA000 the cycle after a granted request.
module tb_if_id_stage;

`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        jump;
  logic [15:0] jaddr;
  logic        gnt;
  logic [15:0] inst;
  logic [15:0] pcq;
  logic        valid;
  logic [15:0] fcnt;
  logic [15:0] bcnt;

  int vectors = 0;
  int errs    = 0;

  if_id_stage_if #(.PC_W(16), .INST_W(16)) imem ();

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .IF_ID_PAUSE   (pause),
    .JUMP_EN       (jump),
    .JUMP_ADDR     (jaddr),
    .imem          (imem),
    .IF_ID_INST    (inst),
    .IF_ID_PC      (pcq),
    .IF_ID_VALID   (valid),
    .IF_FETCH_CNT  (fcnt),
    .IF_BUBBLE_CNT (bcnt)
  );

  always #5 clk = ~clk;

  assign imem.IMEM_GNT = gnt;

  always @(posedge clk) begin
    if (imem.IMEM_REQ && gnt)
      imem.IMEM_RDATA <= imem.IMEM_ADDR ^ 16'hA000;
    else
      imem.IMEM_RDATA <= 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: granted addresses queue up and leave in order.
  logic [15:0] qa[$];
  int          qc[$];
  logic [15:0] npc;
  logic [15:0] e_inst;
  logic [15:0] e_pc;
  logic        e_valid;
  logic [15:0] e_f;
  logic [15:0] e_b;
  logic        e_req;
  bit          have_exp = 1'b0;
  int          cyc = 0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (have_exp) begin
      chk("if_id_inst", {16'h0, inst}, {16'h0, e_inst});
      chk("if_id_pc", {16'h0, pcq}, {16'h0, e_pc});
      chk("if_id_valid", {31'h0, valid}, {31'h0, e_valid});
      chk("fetch_cnt", {16'h0, fcnt}, {16'h0, PERF ? e_f : 16'h0});
      chk("bubble_cnt", {16'h0, bcnt}, {16'h0, PERF ? e_b : 16'h0});
    end
    if (rst) begin
      chk("req_in_rst", {31'h0, imem.IMEM_REQ}, 32'h0);
      qa.delete();
      qc.delete();
      npc = 16'h0000;
      e_inst = 16'h0800; e_pc = 16'h0; e_valid = 1'b0;
      e_f = 16'h0; e_b = 16'h0;
    end else if (jump) begin
      chk("req_on_jump", {31'h0, imem.IMEM_REQ}, 32'h0);
      qa.delete();
      qc.delete();
      npc = jaddr;
      e_inst = 16'h0800; e_pc = 16'h0; e_valid = 1'b0;
      e_b = sat(e_b);
    end else begin
      e_req = !(qa.size() > 0 && (qc[0] < cyc - 1 || pause));
      chk("imem_req", {31'h0, imem.IMEM_REQ}, {31'h0, e_req});
      if (e_req)
        chk("imem_addr", {16'h0, imem.IMEM_ADDR}, {16'h0, npc});
      if (!pause) begin
        if (qa.size() > 0 && qc[0] < cyc) begin
          e_inst  = qa[0] ^ 16'hA000;
          e_pc    = qa[0] + 16'd1;
          e_valid = 1'b1;
          e_f     = sat(e_f);
          void'(qa.pop_front());
          void'(qc.pop_front());
        end else begin
          e_inst = 16'h0800; e_pc = 16'h0; e_valid = 1'b0;
          e_b = sat(e_b);
        end
      end
      if (e_req && gnt) begin
        qa.push_back(npc);
        qc.push_back(cyc);
        npc = npc + 16'd1;
      end
    end
    have_exp = 1'b1;
  end

  task automatic step(input logic g, input logic p, input logic j,
                      input logic [15:0] ja);
    gnt = g; pause = p; jump = j; jaddr = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [15:0] ei,
                     input logic [15:0] ep, input logic ev);
    chk({name, "_inst"}, {16'h0, inst}, {16'h0, ei});
    chk({name, "_pc"}, {16'h0, pcq}, {16'h0, ep});
    chk({name, "_valid"}, {31'h0, valid}, {31'h0, ev});
  endtask

  logic [2:0] tbl [24] = '{
    3'b100, 3'b100, 3'b110, 3'b100, 3'b000, 3'b100, 3'b101, 3'b100,
    3'b100, 3'b010, 3'b110, 3'b100, 3'b000, 3'b000, 3'b110, 3'b111,
    3'b100, 3'b100, 3'b100, 3'b010, 3'b000, 3'b100, 3'b001, 3'b100
  };

  initial begin
    rst = 1'b1; gnt = 1'b1; pause = 1'b0; jump = 1'b0; jaddr = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    lit("reset", 16'h0800, 16'h0000, 1'b0);
    rst = 1'b0;

    step(1, 0, 0, 0);
    lit("first_bubble", 16'h0800, 16'h0000, 1'b0);
    step(1, 0, 0, 0);
    lit("first_inst", 16'hA000, 16'h0001, 1'b1);
    step(1, 0, 0, 0);
    lit("second_inst", 16'hA001, 16'h0002, 1'b1);

    repeat (4) step(0, 0, 0, 0);
    lit("no_grant", 16'h0800, 16'h0000, 1'b0);
    repeat (3) step(1, 0, 0, 0);
    lit("resume", 16'hA004, 16'h0005, 1'b1);

    repeat (4) step(1, 1, 0, 0);
    lit("paused_hold", 16'hA004, 16'h0005, 1'b1);
    step(1, 0, 0, 0);
    lit("skid_out", 16'hA005, 16'h0006, 1'b1);
    step(1, 0, 0, 0);
    lit("after_skid", 16'h0800, 16'h0000, 1'b0);
    step(1, 0, 0, 0);
    lit("refetch", 16'hA006, 16'h0007, 1'b1);

    step(1, 0, 1, 16'h0040);
    lit("jump_bubble", 16'h0800, 16'h0000, 1'b0);
    repeat (2) step(1, 0, 0, 0);
    lit("jump_target", 16'hA040, 16'h0041, 1'b1);

    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 16'h0080);
    lit("jump_in_hold", 16'h0800, 16'h0000, 1'b0);
    repeat (2) step(1, 0, 0, 0);
    lit("hold_target", 16'hA080, 16'h0081, 1'b1);

    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("wrap_ffff", 16'h5FFF, 16'h0000, 1'b1);
    step(1, 0, 0, 0);
    lit("wrap_0000", 16'hA000, 16'h0001, 1'b1);

    foreach (tbl[i]) begin
      logic [2:0] v;
      v = tbl[i];
      step(v[2], v[1], v[0], 16'h0100 + 16'(i));
    end
    repeat (3) step(1, 0, 0, 0);

    rst = 1'b1;
    step(1, 0, 0, 0);
    lit("reset_again", 16'h0800, 16'h0000, 1'b0);
    chk("fetch_cnt_rst", {16'h0, fcnt}, 32'h0);
    chk("bubble_cnt_rst", {16'h0, bcnt}, 32'h0);
    rst = 1'b0;
    repeat (2) step(1, 0, 0, 0);
    lit("post_reset", 16'hA000, 16'h0001, 1'b1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
